// File: rtl/wb_arbiter_if.sv
// Write-port bus bundle between the pipeline, the long-latency unit, the arbiter and the register file.
interface wb_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  pipe_wr_en;
  logic [4:0]            pipe_wr_addr;
  logic [DATA_WIDTH-1:0] pipe_wr_data;
  logic                  lu_valid;
  logic                  lu_ready;
  logic [4:0]            lu_wr_addr;
  logic [DATA_WIDTH-1:0] lu_wr_data;
  logic                  rf_wr_en;
  logic [4:0]            rf_wr_addr;
  logic [DATA_WIDTH-1:0] rf_wr_data;

  // Arbiter side
  modport slave (
    input  pipe_wr_en, pipe_wr_addr, pipe_wr_data,
    input  lu_valid, lu_wr_addr, lu_wr_data,
    output lu_ready,
    output rf_wr_en, rf_wr_addr, rf_wr_data
  );

  // Sources and register-file side
  modport master (
    output pipe_wr_en, pipe_wr_addr, pipe_wr_data,
    output lu_valid, lu_wr_addr, lu_wr_data,
    input  lu_ready,
    input  rf_wr_en, rf_wr_addr, rf_wr_data
  );
endinterface

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: pipeline write-back has priority, long-latency
// results are bypassed when possible or queued in order and drained into idle slots.
module wb_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  wb_arbiter_if.slave                   bus,
  output logic [31:0]                   pending_mask,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          waw_err
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [4:0]            addr;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  entry_t                mem_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] valid_q;
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [PTR_W-1:0]      rd_ptr_q;

  logic pipe_used;
  logic fifo_empty;
  logic lu_xfer;
  logic lu_nonzero;
  logic pop;
  logic bypass;
  logic push;

  // Handshake depends only on registered occupancy
  assign bus.lu_ready = rst_n && (fifo_count != CNT_W'(FIFO_DEPTH));

  assign pipe_used  = rst_n && bus.pipe_wr_en && (bus.pipe_wr_addr != 5'd0);
  assign fifo_empty = (fifo_count == '0);
  assign lu_xfer    = bus.lu_valid && bus.lu_ready;
  assign lu_nonzero = (bus.lu_wr_addr != 5'd0);
  assign pop        = rst_n && !pipe_used && !fifo_empty;
  assign bypass     = !pipe_used && fifo_empty && lu_xfer && lu_nonzero;
  assign push       = lu_xfer && lu_nonzero && !bypass;

  // Write-port mux, fixed priority: pipeline, FIFO head, bypass
  always_comb begin
    bus.rf_wr_en   = 1'b0;
    bus.rf_wr_addr = 5'd0;
    bus.rf_wr_data = '0;
    if (pipe_used) begin
      bus.rf_wr_en   = 1'b1;
      bus.rf_wr_addr = bus.pipe_wr_addr;
      bus.rf_wr_data = bus.pipe_wr_data;
    end else if (pop) begin
      bus.rf_wr_en   = 1'b1;
      bus.rf_wr_addr = mem_q[rd_ptr_q].addr;
      bus.rf_wr_data = mem_q[rd_ptr_q].data;
    end else if (bypass) begin
      bus.rf_wr_en   = 1'b1;
      bus.rf_wr_addr = bus.lu_wr_addr;
      bus.rf_wr_data = bus.lu_wr_data;
    end
  end

  // Pending mask from queued entries only
  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
      if (valid_q[i]) pending_mask[mem_q[i].addr] = 1'b1;
    end
  end

  // FIFO storage, pointers and occupancy; push and pop never hit the same slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
      valid_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q]   <= '{addr: bus.lu_wr_addr, data: bus.lu_wr_data};
        valid_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q          <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        valid_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q          <= rd_ptr_q + PTR_W'(1);
      end
      fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Sticky write-after-write violation flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      waw_err <= 1'b0;
    end else if (pipe_used && pending_mask[bus.pipe_wr_addr]) begin
      waw_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: queue-based reference model, directed and random stimulus.
module tb_wb_arbiter;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [4:0]    addr;
    logic [DW-1:0] data;
  } wr_t;

  typedef struct packed {
    logic          ready;
    logic [CW-1:0] count;
    logic [31:0]   mask;
    logic          waw;
  } stat_t;

  logic          clk;
  logic          rst_n;
  logic [31:0]   pending_mask;
  logic [CW-1:0] fifo_count;
  logic          waw_err;

  wb_arbiter_if #(.DATA_WIDTH(DW)) bus ();

  wb_arbiter #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus.slave),
    .pending_mask (pending_mask),
    .fifo_count   (fifo_count),
    .waw_err      (waw_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  wr_t   exp_wr [$];
  stat_t stat_q [$];
  wr_t   mdl_q  [$];
  logic  mdl_waw = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_idle();
    bus.pipe_wr_en   = 1'b0;
    bus.pipe_wr_addr = 5'd0;
    bus.pipe_wr_data = '0;
    bus.lu_valid     = 1'b0;
    bus.lu_wr_addr   = 5'd0;
    bus.lu_wr_data   = '0;
  endtask

  // One clock of stimulus; the model predicts this cycle's write and status, then advances
  task automatic cycle(input logic pe, input logic [4:0] pa, input logic [DW-1:0] pd,
                       input logic lv, input logic [4:0] la, input logic [DW-1:0] ld,
                       output logic acc);
    stat_t       s;
    logic [31:0] mask;
    logic        ready;
    logic        pu;
    logic        bypassed;
    @(posedge clk);
    #1;
    bus.pipe_wr_en   = pe;
    bus.pipe_wr_addr = pa;
    bus.pipe_wr_data = pd;
    bus.lu_valid     = lv;
    bus.lu_wr_addr   = la;
    bus.lu_wr_data   = ld;
    mask = '0;
    foreach (mdl_q[i]) mask[mdl_q[i].addr] = 1'b1;
    ready = (mdl_q.size() < int'(DEPTH));
    s.ready = ready;
    s.count = CW'(mdl_q.size());
    s.mask  = mask;
    s.waw   = mdl_waw;
    stat_q.push_back(s);
    acc      = lv && ready;
    pu       = pe && (pa != 5'd0);
    bypassed = 1'b0;
    if (pu) begin
      exp_wr.push_back('{addr: pa, data: pd});
      if (mask[pa]) mdl_waw = 1'b1;
    end else if (mdl_q.size() > 0) begin
      exp_wr.push_back(mdl_q.pop_front());
    end else if (acc && la != 5'd0) begin
      exp_wr.push_back('{addr: la, data: ld});
      bypassed = 1'b1;
    end
    if (acc && la != 5'd0 && !bypassed) mdl_q.push_back('{addr: la, data: ld});
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".fifo_count"},   64'(fifo_count),     64'd0);
    chk({tag, ".pending_mask"}, 64'(pending_mask),   64'd0);
    chk({tag, ".lu_ready"},     64'(bus.lu_ready),   64'd0);
    chk({tag, ".rf_wr_en"},     64'(bus.rf_wr_en),   64'd0);
    chk({tag, ".rf_wr_addr"},   64'(bus.rf_wr_addr), 64'd0);
    chk({tag, ".rf_wr_data"},   64'(bus.rf_wr_data), 64'd0);
    chk({tag, ".waw_err"},      64'(waw_err),        64'd0);
  endtask

  // Monitor: compare status every cycle and each presented write against the scoreboard
  stat_t m_s;
  wr_t   m_w;
  always @(negedge clk) begin
    if (rst_n) begin
      if (stat_q.size() > 0) begin
        m_s = stat_q.pop_front();
        chk("lu_ready",     64'(bus.lu_ready), 64'(m_s.ready));
        chk("fifo_count",   64'(fifo_count),   64'(m_s.count));
        chk("pending_mask", 64'(pending_mask), 64'(m_s.mask));
        chk("waw_err",      64'(waw_err),      64'(m_s.waw));
      end
      if (bus.rf_wr_en) begin
        if (exp_wr.size() == 0) begin
          chk("unexpected_write", 64'(bus.rf_wr_addr), 64'h0_dead_beef);
        end else begin
          m_w = exp_wr.pop_front();
          chk("rf_wr_addr", 64'(bus.rf_wr_addr), 64'(m_w.addr));
          chk("rf_wr_data", 64'(bus.rf_wr_data), 64'(m_w.data));
        end
      end else begin
        chk("idle_bus", 64'({bus.rf_wr_addr, bus.rf_wr_data}), 64'd0);
      end
    end
  end

  logic [4:0]    full_addrs [5];
  logic          acc;
  logic          lu_has;
  logic [4:0]    lu_a;
  logic [DW-1:0] lu_d;
  int            idx;

  initial begin
    rst_n = 1'b0;
    drive_idle();
    #2;
    check_reset_outputs("por");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Bypass into an idle port
    cycle(1'b0, 5'd0, '0, 1'b1, 5'd5, 32'hA5A5A5A5, acc);
    // Pipeline wins, long-latency result queued then drained
    cycle(1'b1, 5'd3, 32'h11, 1'b1, 5'd7, 32'h22, acc);
    cycle(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, acc);
    cycle(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, acc);

    // Fill to full under a busy pipeline, then drain in order
    full_addrs[0] = 5'd8;  full_addrs[1] = 5'd9;  full_addrs[2] = 5'd10;
    full_addrs[3] = 5'd11; full_addrs[4] = 5'd12;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      cycle(1'b1, 5'd1, DW'(32'h100 + c), 1'b1, full_addrs[idx], DW'(32'hF00 + idx), acc);
      if (acc) idx++;
    end
    chk("full_accepts", 64'(idx), 64'd4);
    for (int c = 0; c < 20 && idx < 5; c++) begin
      cycle(1'b0, 5'd0, '0, 1'b1, full_addrs[idx], DW'(32'hF00 + idx), acc);
      if (acc) idx++;
    end
    chk("full_drain_accepts", 64'(idx), 64'd5);
    repeat (6) cycle(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, acc);

    // x0 filtering, then a queued head drains in an x0 pipeline slot
    cycle(1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd0, 32'h33, acc);
    chk("x0_accepted", 64'(acc), 64'd1);
    cycle(1'b1, 5'd2, 32'h44, 1'b1, 5'd4, 32'h55, acc);
    cycle(1'b1, 5'd0, 32'hBEEF, 1'b1, 5'd0, 32'h66, acc);
    cycle(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, acc);

    // WAW against a queued entry
    cycle(1'b1, 5'd3, 32'h88, 1'b1, 5'd9, 32'h99, acc);
    cycle(1'b1, 5'd9, 32'h77, 1'b0, 5'd0, '0, acc);
    repeat (3) cycle(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, acc);

    // Randomized traffic with a holding long-latency source
    lu_has = 1'b0;
    lu_a   = '0;
    lu_d   = '0;
    for (int c = 0; c < 400; c++) begin
      logic          pe;
      logic [4:0]    pa;
      logic [DW-1:0] pd;
      if (!lu_has && $urandom_range(0, 9) < 6) begin
        lu_has = 1'b1;
        lu_a   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        lu_d   = DW'($urandom);
      end
      pe = ($urandom_range(0, 9) < 5);
      pa = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      pd = DW'($urandom);
      cycle(pe, pa, pd, lu_has, lu_a, lu_d, acc);
      if (acc) lu_has = 1'b0;
    end
    repeat (6) cycle(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, acc);

    // Asynchronous reset mid-cycle with three entries queued
    for (int c = 0; c < 3; c++) cycle(1'b1, 5'd1, DW'(c), 1'b1, 5'(20 + c), DW'(32'h200 + c), acc);
    @(posedge clk);
    #2;
    chk("pre_reset_count", 64'(fifo_count), 64'd3);
    drive_idle();
    rst_n = 1'b0;
    stat_q.delete();
    exp_wr.delete();
    mdl_q.delete();
    mdl_waw = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle(1'b0, 5'd0, '0, 1'b1, 5'd6, 32'h1234, acc);
    cycle(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, acc);

    @(negedge clk);
    #1;
    chk("writes_outstanding", 64'(exp_wr.size()), 64'd0);
    chk("status_outstanding", 64'(stat_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
